div_arbiter: RTL and testbench

//  Shares one Q16.16 `divider` instance among NREQ requesters (e.g. CORDIC, normaliser, host).

---
 rtl/div_arb_pkg.sv | 32 +++
 rtl/div_arbiter_rr_pick.sv | 36 +++
 rtl/div_arbiter.sv | 156 +++++++++++++++
 tb/tb_div_arbiter.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared encodings for div_arbiter: FSM states, response status codes and the
// saturation value returned for failed divisions.
package div_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_t;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_DBZ = 2'b01;
    localparam logic [1:0] ST_OVF = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;

    localparam int WAIT_CNT_W = 8;

    // A done without valid and without flags means the divider overflowed late
    // in its iteration, so its quotient is not trustworthy.
    function automatic logic [1:0] classify(input logic dbz, input logic ovf, input logic valid);
        logic [1:0] st;
        if (dbz)        st = ST_DBZ;
        else if (ovf)   st = ST_OVF;
        else if (valid) st = ST_OK;
        else            st = ST_OVF;
        return st;
    endfunction

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr (wrapping)
// wins; returns one-hot grant, its index and an any-request flag.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);

    assign any = |req;

    always_comb begin : pick
        logic [IDW:0] slot;
        logic         found;
        // NOTE: every variable gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        slot  = '0;
        for (int i = 0; i < N; i++) begin
            slot = {1'b0, ptr} + (IDW + 1)'(i);
            if (slot >= (IDW + 1)'(N)) slot = slot - (IDW + 1)'(N);
            if (!found && req[slot[IDW-1:0]]) begin
                found                = 1'b1;
                grant[slot[IDW-1:0]] = 1'b1;
                idx                  = slot[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one Q16.16 divider among NREQ requesters with round-robin arbitration.
// Optional WAIT-state watchdog enabled by defining DIV_ARB_TIMEOUT_EN.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int  NREQ    = 4,
    parameter int  WIDTH   = 32,
    parameter int  TIMEOUT = 128,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_val,
    output logic [1:0]            rsp_status,
    output logic [IDW-1:0]        rsp_id,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_a,
    output logic [WIDTH-1:0]      div_b,
    input  logic                  div_busy,
    input  logic                  div_done,
    input  logic                  div_valid,
    input  logic                  div_dbz,
    input  logic                  div_ovf,
    input  logic [WIDTH-1:0]      div_val,
    output logic                  arb_busy
);

    localparam logic [WIDTH-1:0] SAT = {1'b0, {(WIDTH - 1){1'b1}}};

    arb_state_t       state, state_d;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   owner;
    logic [WIDTH-1:0] op_a, op_b;
    logic             timeout_hit;
    logic             unused_inputs;

    logic [NREQ-1:0]  pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;

    logic [WIDTH-1:0] slot_a [NREQ];
    logic [WIDTH-1:0] slot_b [NREQ];

    logic [1:0]       status_now;
    logic [WIDTH-1:0] val_now;

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign slot_a[i] = req_a[i*WIDTH +: WIDTH];
        assign slot_b[i] = req_b[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (pick_any) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (div_done || timeout_hit) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------- result classification
    assign status_now = classify(div_dbz, div_ovf, div_valid);
    assign val_now    = (status_now == ST_OK) ? div_val : SAT;

    // -------------------------------------------- operand and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            owner      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_val    <= '0;
            rsp_status <= ST_OK;
            rsp_id     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        owner <= pick_idx;
                        op_a  <= slot_a[pick_idx];
                        op_b  <= slot_b[pick_idx];
                    end
                end
                S_WAIT: begin
                    // A real completion wins over a watchdog expiry in the same cycle.
                    if (div_done) begin
                        rsp_status <= status_now;
                        rsp_val    <= val_now;
                        rsp_id     <= owner;
                    end else if (timeout_hit) begin
                        rsp_status <= ST_TMO;
                        rsp_val    <= SAT;
                        rsp_id     <= owner;
                    end
                end
                S_RESP: begin
                    ptr <= (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);
                end
                default: ;
            endcase
        end
    end

    // ----------------------------------------------------------- watchdog
`ifdef DIV_ARB_TIMEOUT_EN
    logic [WAIT_CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  wait_cnt <= '0;
        else if (state == S_ISSUE) wait_cnt <= '0;
        else if (state == S_WAIT)  wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout_hit   = (state == S_WAIT) && (wait_cnt == WAIT_CNT_W'(TIMEOUT - 1));
    assign unused_inputs = div_busy;
`else
    assign timeout_hit   = 1'b0;
    assign unused_inputs = div_busy ^ (TIMEOUT == 0);
`endif

    // ------------------------------------------------------------ outputs
    // Grant is gated by rst so nothing is accepted while reset is held.
    assign req_ready = (state == S_IDLE && !rst) ? pick_grant : '0;
    assign rsp_valid = (state == S_RESP) ? (NREQ'(1) << rsp_id) : '0;
    assign div_start = (state == S_ISSUE);
    assign div_a     = op_a;
    assign div_b     = op_b;
    assign arb_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural Q16.16 divider model
// and a response scoreboard. Define DIV_ARB_TIMEOUT_EN to also run the watchdog test.
module tb_div_arbiter;
    import div_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 128;
    localparam int IDW     = 2;
    localparam int BUDGET  = 400;
    localparam int D_FAST  = 2;   // div_start cycle -> div_done cycle, dbz/ovf
    localparam int D_SLOW  = 7;   // div_start cycle -> div_done cycle, normal

    typedef struct {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] val;
        logic [1:0]       st;
    } exp_t;

    typedef struct packed {
        logic        dbz;
        logic        ovf;
        logic [31:0] q;
    } dres_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_val;
    logic [1:0]            rsp_status;
    logic [IDW-1:0]        rsp_id;
    logic                  div_start;
    logic [WIDTH-1:0]      div_a, div_b;
    logic                  div_busy, div_done, div_valid, div_dbz, div_ovf;
    logic [WIDTH-1:0]      div_val;
    logic                  arb_busy;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   stub_mode = 0;      // 0 normal, 1 never done, 2 done without flags
    logic spur_done = 1'b0;

    always #5 clk = ~clk;

    div_arbiter #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_val    (rsp_val),
        .rsp_status (rsp_status),
        .rsp_id     (rsp_id),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_valid  (div_valid),
        .div_dbz    (div_dbz),
        .div_ovf    (div_ovf),
        .div_val    (div_val),
        .arb_busy   (arb_busy)
    );

    // ------------------------------------------------------- divider model
    function automatic dres_t ref_div(input logic [31:0] a, input logic [31:0] b);
        dres_t  r;
        longint sa, sbv, qa;
        r = '0;
        if (b == 32'd0) begin
            r.dbz = 1'b1;
        end else begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            qa  = (sa * 65536) / sbv;
            r.q = qa[31:0];
            if (qa > 64'sd2147483647 || qa < -64'sd2147483648) r.ovf = 1'b1;
        end
        return r;
    endfunction

    function automatic exp_t exp_of(input int id, input logic [31:0] a, input logic [31:0] b);
        exp_t  e;
        dres_t r;
        r    = ref_div(a, b);
        e.id = IDW'(id);
        if (r.dbz)      begin e.st = ST_DBZ; e.val = SAT_MAX; end
        else if (r.ovf) begin e.st = ST_OVF; e.val = SAT_MAX; end
        else            begin e.st = ST_OK;  e.val = r.q;     end
        return e;
    endfunction

    dres_t p;
    int    m_cnt;
    logic  m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done <= 1'b0; div_dbz <= 1'b0; div_ovf <= 1'b0; div_valid <= 1'b0;
            div_val <= '0; p <= '0; m_cnt <= 0;
        end else begin
            m_done <= 1'b0;
            if (div_start) begin
                p     <= ref_div(div_a, div_b);
                m_cnt <= (ref_div(div_a, div_b).dbz || ref_div(div_a, div_b).ovf) ? D_FAST - 1 : D_SLOW - 1;
            end else if (m_cnt == 1) begin
                m_cnt <= 0;
                if (stub_mode == 2) begin
                    m_done <= 1'b1; div_dbz <= 1'b0; div_ovf <= 1'b0; div_valid <= 1'b0;
                    div_val <= 32'h1234_5678;
                end else if (stub_mode == 0) begin
                    m_done <= 1'b1; div_dbz <= p.dbz; div_ovf <= p.ovf;
                    div_valid <= !(p.dbz || p.ovf); div_val <= p.q;
                end
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign div_done = m_done | spur_done;
    assign div_busy = (m_cnt != 0);

    // ------------------------------------------------------- stimulus helpers
    task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_valid[id]            = 1'b1;
    endtask

    task automatic wait_rsp(input int k0, output int k);
        k = k0;
        do begin
            @(negedge clk);
            k++;
            req_valid = '0;
        end while (rsp_valid == '0 && k < BUDGET);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({arb_busy, div_start, req_ready, rsp_valid} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0", {arb_busy, div_start, req_ready, rsp_valid});
        end
        n_chk++;
        if ({div_a, div_b, rsp_val} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h want 0", div_a, div_b, rsp_val);
        end
        n_chk++;
        if ({rsp_status, rsp_id} !== '0) begin
            n_fail++; $display("FAIL reset_status: got %b %b want 0", rsp_status, rsp_id);
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (arb_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: arb_busy %b want 0", arb_busy);
        end
    endtask

    task automatic test_basic();
        int   k;
        exp_t e;
        @(negedge clk);
        drive_req(0, 32'h0003_0000, 32'h0002_0000);
        sb.push_back(exp_t'{id: 2'd0, val: 32'h0001_8000, st: ST_OK});
        #1;
        n_chk++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL basic_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        n_chk++;
        if (div_start !== 1'b1 || div_a !== 32'h0003_0000 || div_b !== 32'h0002_0000) begin
            n_fail++; $display("FAIL basic_issue: start %b a %h b %h", div_start, div_a, div_b);
        end
        req_valid = '0;
        req_a[31:0] = 32'hDEAD_BEEF;
        @(negedge clk);
        n_chk++;
        if (div_start !== 1'b0 || div_a !== 32'h0003_0000 || arb_busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_hold: start %b a %h busy %b", div_start, div_a, arb_busy);
        end
        wait_rsp(2, k);
        e = sb.pop_front();
        n_chk++;
        if (k !== 2 + D_SLOW) begin
            n_fail++; $display("FAIL basic_latency: got %0d want %0d", k, 2 + D_SLOW);
        end
        n_chk++;
        if (rsp_valid !== 4'(1 << e.id) || rsp_id !== e.id) begin
            n_fail++; $display("FAIL basic_owner: valid %b id %0d want id %0d", rsp_valid, rsp_id, e.id);
        end
        n_chk++;
        if (rsp_val !== e.val || rsp_status !== e.st) begin
            n_fail++; $display("FAIL basic_result: got %h/%b want %h/%b", rsp_val, rsp_status, e.val, e.st);
        end
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== '0 || rsp_val !== 32'h0001_8000 || arb_busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_after: valid %b val %h busy %b", rsp_valid, rsp_val, arb_busy);
        end
    endtask

    task automatic test_dbz();
        int   k;
        exp_t e;
        @(negedge clk);
        drive_req(2, 32'h0001_0000, 32'h0000_0000);
        sb.push_back(exp_t'{id: 2'd2, val: 32'h7FFF_FFFF, st: ST_DBZ});
        #1;
        n_chk++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL dbz_grant: got %b want 0100", req_ready);
        end
        wait_rsp(0, k);
        e = sb.pop_front();
        n_chk++;
        if (k !== 4) begin
            n_fail++; $display("FAIL dbz_latency: got %0d want 4", k);
        end
        n_chk++;
        if (rsp_valid !== 4'(1 << e.id) || rsp_val !== e.val || rsp_status !== e.st) begin
            n_fail++; $display("FAIL dbz_result: valid %b val %h st %b want %h/%b", rsp_valid, rsp_val, rsp_status, e.val, e.st);
        end
    endtask

    task automatic test_signed_ovf();
        int   k;
        exp_t e;
        @(negedge clk);
        drive_req(1, 32'hFFFF_0000, 32'h0004_0000);
        sb.push_back(exp_t'{id: 2'd1, val: 32'hFFFF_C000, st: ST_OK});
        wait_rsp(0, k);
        e = sb.pop_front();
        n_chk++;
        if (rsp_valid !== 4'b0010 || rsp_val !== e.val || rsp_status !== e.st) begin
            n_fail++; $display("FAIL neg_result: valid %b val %h st %b want %h/%b", rsp_valid, rsp_val, rsp_status, e.val, e.st);
        end
        @(negedge clk);
        drive_req(1, 32'h7FFF_0000, 32'h0000_0100);
        sb.push_back(exp_t'{id: 2'd1, val: 32'h7FFF_FFFF, st: ST_OVF});
        wait_rsp(0, k);
        e = sb.pop_front();
        n_chk++;
        if (k !== 4 || rsp_valid !== 4'b0010) begin
            n_fail++; $display("FAIL ovf_timing: k %0d valid %b want 4 / 0010", k, rsp_valid);
        end
        n_chk++;
        if (rsp_val !== e.val || rsp_status !== e.st) begin
            n_fail++; $display("FAIL ovf_result: got %h/%b want %h/%b", rsp_val, rsp_status, e.val, e.st);
        end
    endtask

    task automatic test_late_ovf();
        int   k;
        exp_t e;
        stub_mode = 2;
        @(negedge clk);
        drive_req(3, 32'h0001_0000, 32'h0001_0000);
        sb.push_back(exp_t'{id: 2'd3, val: 32'h7FFF_FFFF, st: ST_OVF});
        wait_rsp(0, k);
        e = sb.pop_front();
        n_chk++;
        if (rsp_valid !== 4'b1000 || rsp_val !== e.val || rsp_status !== e.st) begin
            n_fail++; $display("FAIL late_ovf: valid %b val %h st %b want %h/%b", rsp_valid, rsp_val, rsp_status, e.val, e.st);
        end
        stub_mode = 0;
    endtask

    task automatic test_spurious();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid != '0 || arb_busy) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL spurious_done: activity %b want 0", seen);
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        int   id, c;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) drive_req(i, 32'((i + 1) << 16), 32'h0002_0000);
        @(negedge clk);
        n_chk++;
        if (req_ready !== '0) begin
            n_fail++; $display("FAIL rot_in_reset: req_ready %b want 0", req_ready);
        end
        rst = 1'b0;
        #1;
        for (int t = 0; t < 5; t++) begin
            id = t % NREQ;
            sb.push_back(exp_of(id, 32'((id + 1) << 16), 32'h0002_0000));
            c = 0;
            while (req_ready == '0 && c < BUDGET) begin @(negedge clk); c++; end
            n_chk++;
            if (req_ready !== 4'(1 << id)) begin
                n_fail++; $display("FAIL rot_grant%0d: got %b want %b", t, req_ready, 4'(1 << id));
            end
            c = 0;
            do begin @(negedge clk); c++; end while (rsp_valid == '0 && c < BUDGET);
            e = sb.pop_front();
            n_chk++;
            if (rsp_valid !== 4'(1 << e.id) || rsp_id !== e.id || rsp_val !== e.val || rsp_status !== e.st) begin
                n_fail++; $display("FAIL rot_rsp%0d: valid %b id %0d val %h st %b want id %0d val %h", t, rsp_valid, rsp_id, rsp_val, rsp_status, e.id, e.val);
            end
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int   k;
        exp_t e;
        logic seen;
        @(negedge clk);
        drive_req(2, 32'h0005_0000, 32'h0002_0000);
        wait_rsp(0, k);
        n_chk++;
        if (rsp_valid !== 4'b0100 || rsp_val !== 32'h0002_8000) begin
            n_fail++; $display("FAIL abort_pre: valid %b val %h want 0100/00028000", rsp_valid, rsp_val);
        end
        stub_mode = 1;
        @(negedge clk);
        drive_req(1, 32'h0001_0000, 32'h0003_0000);
        #1;
        n_chk++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL abort_grant: got %b want 0010", req_ready);
        end
        repeat (4) begin @(negedge clk); req_valid = '0; end
        n_chk++;
        if (arb_busy !== 1'b1 || div_a !== 32'h0001_0000) begin
            n_fail++; $display("FAIL abort_wait: busy %b a %h", arb_busy, div_a);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({arb_busy, div_start, rsp_valid, div_a, div_b, rsp_val, rsp_status, rsp_id} !== '0) begin
            n_fail++; $display("FAIL abort_clear: busy %b a %h b %h val %h", arb_busy, div_a, div_b, rsp_val);
        end
        @(negedge clk);
        rst = 1'b0;
        stub_mode = 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid != '0 || arb_busy) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL abort_quiet: activity %b want 0", seen);
        end
        drive_req(1, 32'h0006_0000, 32'h0003_0000);
        drive_req(3, 32'h0001_0000, 32'h0001_0000);
        sb.push_back(exp_t'{id: 2'd1, val: 32'h0002_0000, st: ST_OK});
        #1;
        n_chk++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL abort_ptr: grant %b want 0010", req_ready);
        end
        wait_rsp(0, k);
        e = sb.pop_front();
        n_chk++;
        if (rsp_valid !== 4'(1 << e.id) || rsp_val !== e.val || rsp_status !== e.st) begin
            n_fail++; $display("FAIL abort_fresh: valid %b val %h st %b want %h/%b", rsp_valid, rsp_val, rsp_status, e.val, e.st);
        end
    endtask

`ifdef DIV_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int   k;
        exp_t e;
        logic seen;
        stub_mode = 1;
        @(negedge clk);
        drive_req(0, 32'h0002_0000, 32'h0001_0000);
        sb.push_back(exp_t'{id: 2'd0, val: 32'h7FFF_FFFF, st: ST_TMO});
        wait_rsp(0, k);
        e = sb.pop_front();
        n_chk++;
        if (k !== 2 + TIMEOUT) begin
            n_fail++; $display("FAIL tmo_latency: got %0d want %0d", k, 2 + TIMEOUT);
        end
        n_chk++;
        if (rsp_valid !== 4'b0001 || rsp_val !== e.val || rsp_status !== e.st) begin
            n_fail++; $display("FAIL tmo_result: valid %b val %h st %b want %h/%b", rsp_valid, rsp_val, rsp_status, e.val, e.st);
        end
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL tmo_late_done: response %b want 0", seen);
        end
        stub_mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_dbz();
        test_signed_ovf();
        test_late_ovf();
        test_spurious();
        test_rotation();
        test_reset_abort();
`ifdef DIV_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
